// File: rtl/card_rom_arbiter_pkg.sv
// Shared display constants and arbiter state encoding for the card-sprite lookup.
package card_rom_arbiter_pkg;

    localparam int unsigned CARD_W        = 32;
    localparam int unsigned CARD_H        = 46;
    localparam int unsigned CARD_TYPE_MAX = 53;
    localparam int unsigned PIX_W         = 12;
    localparam int unsigned ID_W          = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    // Round-robin pointer after granting index i among n requesters.
    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] i, input int unsigned n);
        return (32'(i) == n - 1) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/card_rom_arbiter_rr_pick.sv
// Combinational round-robin select: first eligible request at or after ptr wins.
module rr_pick
    import card_rom_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic [N_REQ-1:0] excl,
    output logic [N_REQ-1:0] gnt,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!any && (i == (32'(ptr) + k) % N_REQ) && req[i] && !excl[i]) begin
                    gnt[i] = 1'b1;
                    any    = 1'b1;
                    idx    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/card_rom_arbiter.sv
// Round-robin arbiter with bounded lock driving the shared card-sprite lookup port;
// two-stage pipeline returns the looked-up pixel tagged with the requester id.
module card_rom_arbiter
    import card_rom_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic               clk_25MHz,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_lock,
    input  logic [6*N_REQ-1:0] req_card_type,
    input  logic [6*N_REQ-1:0] req_x,
    input  logic [6*N_REQ-1:0] req_y,
    output logic [N_REQ-1:0]   gnt,
    output logic [5:0]         rom_card_type,
    output logic [5:0]         rom_x,
    output logic [5:0]         rom_y,
    input  logic [PIX_W-1:0]   rom_pixel,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [PIX_W-1:0]   rsp_pixel,
    output logic               rsp_err
);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  owner;
    logic [6:0]       lock_cnt;
    logic [N_REQ-1:0] blocked;

    logic [N_REQ-1:0] owner_oh;
    logic             owner_live;
    logic             owner_hold;
    logic             force_break;
    logic [N_REQ-1:0] excl;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;

    logic             win_any;
    logic [ID_W-1:0]  win_idx;
    logic             win_lock;
    logic             win_err;
    logic [5:0]       win_type;
    logic [5:0]       win_x;
    logic [5:0]       win_y;

    logic             s1_valid;
    logic [ID_W-1:0]  s1_id;
    logic             s1_err;

    // A force-broken owner stays out of arbitration until it drops req_lock.
    always_comb begin
        owner_oh = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            owner_oh[i] = (owner == ID_W'(i));
        end
        owner_live  = (state == ARB_LOCKED) && (|(owner_oh & req & req_lock));
        owner_hold  = owner_live && (lock_cnt < 7'(LOCK_MAX));
        force_break = owner_live && !owner_hold;
        excl        = (blocked & req_lock) | ((state == ARB_LOCKED) ? owner_oh : '0);
    end

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req  (req),
        .ptr  (ptr),
        .excl (excl),
        .gnt  (pick_gnt),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        gnt      = owner_hold ? owner_oh : pick_gnt;
        win_any  = owner_hold || pick_any;
        win_idx  = owner_hold ? owner : pick_idx;
        win_lock = |(gnt & req_lock);
        win_type = '0;
        win_x    = '0;
        win_y    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_type = req_card_type[6*i +: 6];
                win_x    = req_x[6*i +: 6];
                win_y    = req_y[6*i +: 6];
            end
        end
        win_err = (win_type > 6'(CARD_TYPE_MAX)) || (win_x > 6'(CARD_W - 1)) ||
                  (win_y > 6'(CARD_H - 1));
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            state         <= ARB_IDLE;
            ptr           <= '0;
            owner         <= '0;
            lock_cnt      <= '0;
            blocked       <= '0;
            rom_card_type <= '0;
            rom_x         <= '0;
            rom_y         <= '0;
            s1_valid      <= 1'b0;
            s1_id         <= '0;
            s1_err        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_err       <= 1'b0;
        end else begin
            blocked <= (blocked & req_lock) | (force_break ? owner_oh : '0);

            if (win_any) begin
                ptr <= ptr_after(win_idx, N_REQ);
                if (owner_hold) begin
                    lock_cnt <= lock_cnt + 7'd1;
                end else if (win_lock) begin
                    state    <= ARB_LOCKED;
                    owner    <= win_idx;
                    lock_cnt <= 7'd1;
                end else begin
                    state    <= ARB_GRANT;
                    lock_cnt <= '0;
                end
                rom_card_type <= win_err ? '0 : win_type;
                rom_x         <= win_err ? '0 : win_x;
                rom_y         <= win_err ? '0 : win_y;
            end else begin
                state    <= ARB_IDLE;
                lock_cnt <= '0;
            end

            s1_valid  <= win_any;
            s1_id     <= win_idx;
            s1_err    <= win_any && win_err;
            rsp_valid <= s1_valid;
            rsp_id    <= s1_id;
            rsp_err   <= s1_err;
        end
    end

    assign rsp_pixel = (rsp_valid && !rsp_err) ? rom_pixel : '0;

endmodule
